product_accumulator: RTL and testbench

//   Registered consumer stage placed directly after the combinational 8x8 Wallace multiplier.

---
 rtl/product_accumulator_if.sv | 26 ++
 rtl/product_accumulator.sv | 113 +++++++++++
 tb/tb_product_accumulator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Stream bundle between the multiplier front end and the product accumulator.
// master drives products, clear and out_ready; slave returns handshakes and block sums.
interface product_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output clear, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, count, overflow
  );

  modport slave (
    input  clear, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, count, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Clocked MAC back end: sums BLOCK_LEN 16-bit products and presents each block sum on valid/ready.
// Optional macro SAT_ACC_EN: saturating accumulation with a per-block overflow flag.
module product_accumulator #(
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  product_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [ACC_W-1:0] sum;
  logic             beat;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_out   = acc_out_q;
  assign bus.count     = count_q;
  assign beat          = bus.in_valid & bus.in_ready;

`ifdef SAT_ACC_EN
  logic [ACC_W:0] sum_w;
  logic           carry;
  logic           sticky_q, sticky_d;
  logic           ovf_q, ovf_d;

  assign sum_w        = {1'b0, acc_q} + (ACC_W+1)'(bus.product);
  assign carry        = sum_w[ACC_W];
  assign sum          = carry ? '1 : sum_w[ACC_W-1:0];
  assign bus.overflow = ovf_q;
`else
  assign sum          = acc_q + ACC_W'(bus.product);
  assign bus.overflow = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    acc_out_d = acc_out_q;
`ifdef SAT_ACC_EN
    sticky_d  = sticky_q;
    ovf_d     = ovf_q;
`endif
    if (bus.clear) begin
      // Abort drops any pending sum but leaves acc_out showing the last one.
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
`ifdef SAT_ACC_EN
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            if (count_q == LAST) begin
              acc_out_d = sum;
              acc_d     = '0;
              count_d   = '0;
              state_d   = DONE;
`ifdef SAT_ACC_EN
              ovf_d    = sticky_q | carry;
              sticky_d = 1'b0;
`endif
            end else begin
              acc_d   = sum;
              count_d = count_q + 1'b1;
`ifdef SAT_ACC_EN
              sticky_d = sticky_q | carry;
`endif
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      count_q   <= '0;
      acc_out_q <= '0;
`ifdef SAT_ACC_EN
      sticky_q  <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      acc_out_q <= acc_out_d;
`ifdef SAT_ACC_EN
      sticky_q  <= sticky_d;
      ovf_q     <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow (ACC_W=16, BLOCK_LEN=2) and BLOCK_LEN=1 builds.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(24), .CNT_W(8)) if0 ();
  product_accumulator_if #(.ACC_W(16), .CNT_W(8)) if1 ();
  product_accumulator_if #(.ACC_W(24), .CNT_W(8)) if2 ();

  product_accumulator #(.ACC_W(24), .CNT_W(8), .BLOCK_LEN(4)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  product_accumulator #(.ACC_W(16), .CNT_W(8), .BLOCK_LEN(2)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  product_accumulator #(.ACC_W(24), .CNT_W(8), .BLOCK_LEN(1)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  // Advance one rising edge, then settle so outputs reflect the new state.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [15:0] p);
    if0.in_valid = 1'b1;
    if0.product  = p;
    cyc();
    if0.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", if0.out_valid); end
    checks++; if (if0.acc_out !== 24'd0) begin errors++; $display("FAIL reset_acc_out got %0h exp 0", if0.acc_out); end
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if0.count); end
    checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", if0.overflow); end
  endtask

  task automatic test_basic_block();
    if0.out_ready = 1'b1;
    beat0(16'd3);
    checks++; if (if0.count !== 8'd1) begin errors++; $display("FAIL t1_count1 got %0d exp 1", if0.count); end
    beat0(16'd5);
    beat0(16'd7);
    checks++; if (if0.count !== 8'd3) begin errors++; $display("FAIL t1_count3 got %0d exp 3", if0.count); end
    beat0(16'd9);
    checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL t1_out_valid got %b exp 1", if0.out_valid); end
    checks++; if (if0.acc_out !== 24'd24) begin errors++; $display("FAIL t1_acc_out got %0d exp 24", if0.acc_out); end
    checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready_done got %b exp 0", if0.in_ready); end
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t1_count_done got %0d exp 0", if0.count); end
    cyc();
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready_back got %b exp 1", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL t1_out_valid_back got %b exp 0", if0.out_valid); end
  endtask

  task automatic test_backpressure();
    if0.out_ready = 1'b0;
    beat0(16'd10);
    beat0(16'd20);
    beat0(16'd30);
    beat0(16'd40);
    if0.in_valid = 1'b1;
    if0.product  = 16'd99;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL t2_hold_valid[%0d] got %b exp 1", i, if0.out_valid); end
      checks++; if (if0.acc_out !== 24'd100) begin errors++; $display("FAIL t2_hold_acc[%0d] got %0d exp 100", i, if0.acc_out); end
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL t2_hold_ready[%0d] got %b exp 0", i, if0.in_ready); end
      checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t2_hold_count[%0d] got %0d exp 0", i, if0.count); end
      cyc();
    end
    if0.out_ready = 1'b1;
    cyc();
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL t2_release_ready got %b exp 1", if0.in_ready); end
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t2_release_count got %0d exp 0", if0.count); end
    cyc();
    if0.in_valid = 1'b0;
    checks++; if (if0.count !== 8'd1) begin errors++; $display("FAIL t2_next_beat got %0d exp 1", if0.count); end
    if0.clear = 1'b1;
    cyc();
    if0.clear = 1'b0;
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t2_tidy_clear got %0d exp 0", if0.count); end
  endtask

  task automatic test_clear();
    if0.out_ready = 1'b0;
    beat0(16'd100);
    beat0(16'd200);
    if0.clear    = 1'b1;
    if0.in_valid = 1'b1;
    if0.product  = 16'd50;
    cyc();
    if0.clear    = 1'b0;
    if0.in_valid = 1'b0;
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t3_clear_count got %0d exp 0", if0.count); end
    checks++; if (if0.acc_out !== 24'd100) begin errors++; $display("FAIL t3_clear_keeps_acc_out got %0d exp 100", if0.acc_out); end
    beat0(16'd1);
    beat0(16'd2);
    beat0(16'd3);
    beat0(16'd4);
    checks++; if (if0.acc_out !== 24'd10) begin errors++; $display("FAIL t3_acc_out got %0d exp 10", if0.acc_out); end
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t3_count got %0d exp 0", if0.count); end
    // Clear in DONE drops the pending sum.
    if0.clear = 1'b1;
    cyc();
    if0.clear = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL t3_clear_done_valid got %b exp 0", if0.out_valid); end
    checks++; if (if0.acc_out !== 24'd10) begin errors++; $display("FAIL t3_clear_done_acc got %0d exp 10", if0.acc_out); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_sum;
    logic        exp_ovf;
`ifdef SAT_ACC_EN
    exp_sum = 16'hFFFF;
    exp_ovf = 1'b1;
`else
    exp_sum = 16'h0001;
    exp_ovf = 1'b0;
`endif
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.product   = 16'hFE01;
    cyc();
    checks++; if (if1.count !== 8'd1) begin errors++; $display("FAIL t4_count1 got %0d exp 1", if1.count); end
    if1.product = 16'h0200;
    cyc();
    if1.in_valid = 1'b0;
    checks++; if (if1.acc_out !== exp_sum) begin errors++; $display("FAIL t4_acc_out got %0h exp %0h", if1.acc_out, exp_sum); end
    checks++; if (if1.overflow !== exp_ovf) begin errors++; $display("FAIL t4_overflow got %b exp %b", if1.overflow, exp_ovf); end
    checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL t4_out_valid got %b exp 1", if1.out_valid); end
    cyc();
    // A clean block after a saturated one must not inherit the flag.
    if1.in_valid = 1'b1;
    if1.product  = 16'd1;
    cyc();
    if1.product = 16'd2;
    cyc();
    if1.in_valid = 1'b0;
    checks++; if (if1.acc_out !== 16'd3) begin errors++; $display("FAIL t4_clean_acc got %0h exp 3", if1.acc_out); end
    checks++; if (if1.overflow !== 1'b0) begin errors++; $display("FAIL t4_clean_overflow got %b exp 0", if1.overflow); end
    cyc();
  endtask

  task automatic test_reset_midstream();
    if0.out_ready = 1'b0;
    beat0(16'd5);
    beat0(16'd5);
    beat0(16'd5);
    beat0(16'd5);
    checks++; if (if0.acc_out !== 24'd20) begin errors++; $display("FAIL t5_pre_done got %0d exp 20", if0.acc_out); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL t5_rst_done_valid got %b exp 0", if0.out_valid); end
    checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL t5_rst_done_ready got %b exp 1", if0.in_ready); end
    checks++; if (if0.acc_out !== 24'd0) begin errors++; $display("FAIL t5_rst_done_acc got %0d exp 0", if0.acc_out); end
    beat0(16'd1);
    beat0(16'd1);
    checks++; if (if0.count !== 8'd2) begin errors++; $display("FAIL t5_mid_count got %0d exp 2", if0.count); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (if0.count !== 8'd0) begin errors++; $display("FAIL t5_rst_mid_count got %0d exp 0", if0.count); end
    beat0(16'd1);
    beat0(16'd1);
    beat0(16'd1);
    beat0(16'd1);
    checks++; if (if0.acc_out !== 24'd4) begin errors++; $display("FAIL t5_acc_out got %0d exp 4", if0.acc_out); end
    checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL t5_out_valid got %b exp 1", if0.out_valid); end
    if0.out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    if2.out_ready = 1'b1;
    if2.in_valid  = 1'b1;
    if2.product   = 16'hFE01;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (if2.out_valid !== 1'b1) begin errors++; $display("FAIL t6_valid[%0d] got %b exp 1", i, if2.out_valid); end
      checks++; if (if2.acc_out !== 24'h00FE01) begin errors++; $display("FAIL t6_acc[%0d] got %0h exp fe01", i, if2.acc_out); end
      checks++; if (if2.count !== 8'd0) begin errors++; $display("FAIL t6_count[%0d] got %0d exp 0", i, if2.count); end
      cyc();
      checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL t6_ready[%0d] got %b exp 1", i, if2.in_ready); end
      checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL t6_gap[%0d] got %b exp 0", i, if2.out_valid); end
    end
    if2.in_valid = 1'b0;
  endtask

  initial begin
    if0.clear = 1'b0; if0.in_valid = 1'b0; if0.product = '0; if0.out_ready = 1'b0;
    if1.clear = 1'b0; if1.in_valid = 1'b0; if1.product = '0; if1.out_ready = 1'b0;
    if2.clear = 1'b0; if2.in_valid = 1'b0; if2.product = '0; if2.out_ready = 1'b0;
    test_reset();
    test_basic_block();
    test_backpressure();
    test_clear();
    test_overflow();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
